regfile_op_sequencer: RTL and testbench
=======================================

Name: regfile_op_sequencer

Overview:
Initiator for the team's synchronous-write, registered-read register file (M entries x N bits). Accepts ALU-style commands (op, rd, rs1, rs2) over a valid/ready handshake and issues the two reads. It waits one cycle for the registered read data, computes the result, writes it back to rd and reports it on a one-cycle response strobe. Sits between a command source (test sequencer or micro-controller) and a register file instance.

Parameters:
M, 32, register file depth; address width AW = $clog2(M)
N, 32, data width

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
cmd_valid  in  1  command present
cmd_ready  out  1  sequencer can accept a command
cmd_op  in  3  operation code
cmd_rd  in  AW  destination register
cmd_rs1  in  AW  source register 1
cmd_rs2  in  AW  source register 2
rf_r1  out  AW  register file read address 1
rf_r2  out  AW  register file read address 2
rf_q1  in  N  register file read data 1 (registered, 1-cycle latency)
rf_q2  in  N  register file read data 2
rf_we  out  1  register file write enable
rf_rw  out  AW  register file write address
rf_data_in  out  N  register file write data
rsp_valid  out  1  one-cycle result strobe
rsp_data  out  N  result value

Behaviour:
- States: IDLE, RD, WB. Reset enters IDLE. Latched command registers (op, rd, rs1, rs2) reset to 0.
- Reset values: cmd_ready=1 (IDLE), rf_we=0, rsp_valid=0, rf_r1=rf_r2=rf_rw=0, rf_data_in=0, rsp_data=0.
- IDLE: cmd_ready=1. Acceptance happens on a rising edge with cmd_valid&&cmd_ready. At acceptance, latch the fields and go to RD. Without cmd_valid, stay in IDLE.
- RD: cmd_ready=0. rf_r1/rf_r2 are driven from the latched rs1/rs2. They stay stable through RD and WB. The register file captures q1/q2 at the end of RD. Go to WB next.
- WB: cmd_ready=0. The result is computed combinationally from rf_q1/rf_q2 and the latched op. rf_we=1, rf_rw=latched rd, rf_data_in=result, rsp_valid=1, rsp_data=result, all for exactly this cycle. Go to IDLE next.
- rsp_data and rf_data_in are 0 outside WB. rf_we and rsp_valid are asserted only in WB.
- Latency: acceptance edge T; WB is the cycle after edge T+1; the write commits at edge T+2. Throughput is one command per 3 cycles.
- Ops (a=rf_q1, b=rf_q2):
  - 0 ADD: a+b.
  - 1 SUB: a-b.
  - 2 AND.
  - 3 OR.
  - 4 XOR.
  - 5 SLL: a << b[$clog2(N)-1:0].
  - 6 SRL: logical right shift by the same amount.
  - 7 MOV: a.
- Arithmetic wraps modulo 2^N; carry and borrow are discarded.
- rd equal to rs1 or rs2: the operands are read before the write, so the old value is used. Back-to-back dependent commands need no stall, because the next RD follows the previous write edge.
- rs1==rs2 is legal; both ports return the same value.
- cmd_* fields are ignored while cmd_ready=0.
- Async reset mid-operation (RD or WB): return to IDLE immediately. rf_we and rsp_valid drop asynchronously, no write occurs, and the in-flight command is discarded without a response.

Optional Feature:
ZERO_REG_EN. When defined, register 0 is hardwired zero:
- An operand whose latched source address is 0 is forced to 0, whatever rf_q carries.
- A command with rd=0 still produces rsp_valid/rsp_data, but rf_we stays 0 in its WB cycle.

When undefined, register 0 is an ordinary register.

Test Plan:
- Reset: assert rst_n=0 mid-WB of an ADD. rf_we and rsp_valid fall immediately, cmd_ready=1 after release, and the target register is unchanged.
- Preload r1=0x0000_0005, r2=0xFFFF_FFFF; ADD rd=3 rs1=1 rs2=2. rsp_data=0x0000_0004 two cycles after acceptance; a later MOV rd=4 rs1=3 returns 4.
- SUB r5=r1-r2 with r1=0, r2=1 gives 0xFFFF_FFFF. SLL with a=0x1, b=0x25 (shift 5) gives 0x20. SRL with a=0x8000_0000, b=31 gives 0x1.
- Hazard: ADD rd=1 rs1=1 rs2=1 with r1=3 gives 6; the immediately following ADD rd=1 rs1=1 rs2=1 gives 12.
- Handshake: hold cmd_valid high with changing fields for 9 cycles. Exactly 3 acceptances occur, each in IDLE only, and cmd_ready pattern is 1,0,0 repeating.
- With ZERO_REG_EN: preload r0=0x55 via bench backdoor. ADD rd=0 rs1=0 rs2=2 (r2=7) gives rsp_data=7, no rf_we, and r0 remains 0x55 in storage.

Source files
------------

// File: rtl/regfile_op_sequencer_if.sv
// Command, register-file and response signals of regfile_op_sequencer, grouped into one bundle.
// Handshake: a command is accepted on a rising clk edge where cmd_valid && cmd_ready; cmd_* are don't-care otherwise.
interface regfile_op_sequencer_if #(
   parameter int AW = 5,
   parameter int N  = 32
);
   logic          cmd_valid;
   logic          cmd_ready;
   logic [2:0]    cmd_op;
   logic [AW-1:0] cmd_rd;
   logic [AW-1:0] cmd_rs1;
   logic [AW-1:0] cmd_rs2;
   logic [AW-1:0] rf_r1;
   logic [AW-1:0] rf_r2;
   logic [N-1:0]  rf_q1;
   logic [N-1:0]  rf_q2;
   logic          rf_we;
   logic [AW-1:0] rf_rw;
   logic [N-1:0]  rf_data_in;
   logic          rsp_valid;
   logic [N-1:0]  rsp_data;

   // master: the sequencer itself; slave: command source plus register file
   modport master (
      input  cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rf_q1, rf_q2,
      output cmd_ready, rf_r1, rf_r2, rf_we, rf_rw, rf_data_in, rsp_valid, rsp_data
   );
   modport slave (
      output cmd_valid, cmd_op, cmd_rd, cmd_rs1, cmd_rs2, rf_q1, rf_q2,
      input  cmd_ready, rf_r1, rf_r2, rf_we, rf_rw, rf_data_in, rsp_valid, rsp_data
   );
endinterface

// File: rtl/regfile_op_sequencer.sv
// Reads two operands from a registered-read register file, applies an ALU op and writes rd back.
// Optional macro ZERO_REG_EN: register 0 reads as zero and is never written.
module regfile_op_sequencer #(
   parameter int M = 32,
   parameter int N = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   regfile_op_sequencer_if.master bus,
   output logic [1:0]             o_dbg_state
);
   localparam int AW = $clog2(M);
   localparam int SW = $clog2(N);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_WB   = 2'd2
   } state_t;

   state_t        r_state;
   logic          r_cmd_ready;
   logic          r_we;
   logic          r_rsp_valid;
   logic [2:0]    r_op;
   logic [AW-1:0] r_rd;
   logic [AW-1:0] r_rs1;
   logic [AW-1:0] r_rs2;

   logic [N-1:0]  w_a;
   logic [N-1:0]  w_b;
   logic [SW-1:0] w_sh;
   logic [N-1:0]  w_result;
   logic          w_wb_we;

`ifdef ZERO_REG_EN
   assign w_a     = (r_rs1 == '0) ? '0 : bus.rf_q1;
   assign w_b     = (r_rs2 == '0) ? '0 : bus.rf_q2;
   assign w_wb_we = (r_rd != '0);
`else
   assign w_a     = bus.rf_q1;
   assign w_b     = bus.rf_q2;
   assign w_wb_we = 1'b1;
`endif

   assign w_sh = w_b[SW-1:0];

   always_comb begin
      w_result = '0;
      case (r_op)
         3'd0:    w_result = w_a + w_b;
         3'd1:    w_result = w_a - w_b;
         3'd2:    w_result = w_a & w_b;
         3'd3:    w_result = w_a | w_b;
         3'd4:    w_result = w_a ^ w_b;
         3'd5:    w_result = w_a << w_sh;
         3'd6:    w_result = w_a >> w_sh;
         default: w_result = w_a;
      endcase
   end

   // Strobes are registered so an async reset removes them at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_cmd_ready <= 1'b1;
         r_we        <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_op        <= '0;
         r_rd        <= '0;
         r_rs1       <= '0;
         r_rs2       <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (bus.cmd_valid && r_cmd_ready) begin
                  r_op        <= bus.cmd_op;
                  r_rd        <= bus.cmd_rd;
                  r_rs1       <= bus.cmd_rs1;
                  r_rs2       <= bus.cmd_rs2;
                  r_cmd_ready <= 1'b0;
                  r_state     <= S_RD;
               end
            end
            S_RD: begin
               r_we        <= w_wb_we;
               r_rsp_valid <= 1'b1;
               r_state     <= S_WB;
            end
            S_WB: begin
               r_we        <= 1'b0;
               r_rsp_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
            default: begin
               r_we        <= 1'b0;
               r_rsp_valid <= 1'b0;
               r_cmd_ready <= 1'b1;
               r_state     <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.cmd_ready  = r_cmd_ready;
   assign bus.rf_r1      = r_rs1;
   assign bus.rf_r2      = r_rs2;
   assign bus.rf_rw      = r_rd;
   assign bus.rf_we      = r_we;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_data   = r_rsp_valid ? w_result : '0;
   assign bus.rf_data_in = r_rsp_valid ? w_result : '0;
   assign o_dbg_state    = r_state;
endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer: behavioural register file, spec-level ALU model and directed plus random commands.
module tb_regfile_op_sequencer;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic [1:0]  dbg_state;
   logic        bd_we = 1'b0;
   logic [4:0]  bd_addr = '0;
   logic [31:0] bd_data = '0;
   logic [31:0] mem [32];
   logic [31:0] model [32];
   logic [31:0] exp_q [$];
   int          n_vec = 0;
   int          n_err = 0;

   regfile_op_sequencer_if #(.AW(5), .N(32)) bus ();

   regfile_op_sequencer #(.M(32), .N(32)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .bus         (bus.master),
      .o_dbg_state (dbg_state)
   );

   always #5 clk = ~clk;

   // Register file: synchronous write, registered read, plus a bench backdoor port
   always @(posedge clk) begin
      bus.rf_q1 <= mem[bus.rf_r1];
      bus.rf_q2 <= mem[bus.rf_r2];
      if (bd_we) mem[bd_addr] <= bd_data;
      else if (bus.rf_we) mem[bus.rf_rw] <= bus.rf_data_in;
   end

   function automatic logic [31:0] ref_op(input int op, input logic [31:0] a, input logic [31:0] b);
      int sh;
      sh = int'(b % 32);
      case (op)
         0: return a + b;
         1: return a - b;
         2: return a & b;
         3: return a | b;
         4: return a ^ b;
         5: return a << sh;
         6: return a >> sh;
         default: return a;
      endcase
   endfunction

   function automatic logic [31:0] operand(input logic [4:0] addr);
`ifdef ZERO_REG_EN
      if (addr == 5'd0) return 32'd0;
`endif
      return model[addr];
   endfunction

   function automatic logic exp_we(input logic [4:0] rd);
`ifdef ZERO_REG_EN
      return rd != 5'd0;
`else
      return 1'b1;
`endif
   endfunction

   task automatic preload(input logic [4:0] a, input logic [31:0] d);
      @(negedge clk);
      bd_we = 1'b1; bd_addr = a; bd_data = d;
      @(posedge clk);
      #1 bd_we = 1'b0;
      model[a] = d;
   endtask

   task automatic do_cmd(input logic [2:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, output logic [31:0] got);
      logic [31:0] exp;
      int n;
      got = '0;
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_op = op; bus.cmd_rd = rd; bus.cmd_rs1 = rs1; bus.cmd_rs2 = rs2;
      n = 0;
      while (bus.cmd_ready !== 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      n_vec++;
      if (bus.cmd_ready !== 1'b1) begin
         n_err++;
         $display("FAIL accept_timeout: cmd_ready=%b, required 1", bus.cmd_ready);
         bus.cmd_valid = 1'b0;
         return;
      end
      exp_q.push_back(ref_op(int'(op), operand(rs1), operand(rs2)));
      @(posedge clk);
      #1;
      bus.cmd_valid = 1'b0;
      bus.cmd_op = 3'($urandom); bus.cmd_rd = 5'($urandom);
      bus.cmd_rs1 = 5'($urandom); bus.cmd_rs2 = 5'($urandom);
      @(negedge clk);
      n_vec++;
      if (bus.rsp_valid !== 1'b0 || bus.rf_we !== 1'b0 || bus.cmd_ready !== 1'b0 ||
          bus.rf_r1 !== rs1 || bus.rf_r2 !== rs2 || bus.rsp_data !== 32'd0 || bus.rf_data_in !== 32'd0) begin
         n_err++;
         $display("FAIL rd_phase: vld=%b we=%b rdy=%b r1=%0d r2=%0d data=%h, required 0 0 0 %0d %0d 0",
                  bus.rsp_valid, bus.rf_we, bus.cmd_ready, bus.rf_r1, bus.rf_r2, bus.rsp_data, rs1, rs2);
      end
      @(negedge clk);
      exp = exp_q.pop_front();
      got = bus.rsp_data;
      n_vec++;
      if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== exp) begin
         n_err++;
         $display("FAIL rsp op=%0d: valid=%b data=%h, required 1 %h", op, bus.rsp_valid, bus.rsp_data, exp);
      end
      n_vec++;
      if (bus.rf_we !== exp_we(rd) || bus.rf_rw !== rd || bus.rf_data_in !== exp) begin
         n_err++;
         $display("FAIL writeback: we=%b rw=%0d din=%h, required %b %0d %h",
                  bus.rf_we, bus.rf_rw, bus.rf_data_in, exp_we(rd), rd, exp);
      end
      if (exp_we(rd)) model[rd] = exp;
   endtask

   task automatic test_reset();
      #12;
      n_vec++;
      if (bus.cmd_ready !== 1'b1 || bus.rf_we !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.rf_r1 !== 5'd0 ||
          bus.rf_r2 !== 5'd0 || bus.rf_rw !== 5'd0 || bus.rsp_data !== 32'd0 || bus.rf_data_in !== 32'd0) begin
         n_err++;
         $display("FAIL reset_values: rdy=%b we=%b vld=%b r1=%0d r2=%0d rw=%0d data=%h din=%h",
                  bus.cmd_ready, bus.rf_we, bus.rsp_valid, bus.rf_r1, bus.rf_r2, bus.rf_rw,
                  bus.rsp_data, bus.rf_data_in);
      end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_reset_mid_wb();
      preload(5'd1, 32'd2);
      preload(5'd2, 32'd3);
      preload(5'd9, 32'h11);
      @(negedge clk);
      bus.cmd_valid = 1'b1; bus.cmd_op = 3'd0; bus.cmd_rd = 5'd9; bus.cmd_rs1 = 5'd1; bus.cmd_rs2 = 5'd2;
      @(posedge clk);
      #1 bus.cmd_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      n_vec++;
      if (bus.rsp_valid !== 1'b1 || bus.rf_we !== 1'b1) begin
         n_err++;
         $display("FAIL pre_reset_wb: valid=%b we=%b, required 1 1", bus.rsp_valid, bus.rf_we);
      end
      #2 rst_n = 1'b0;
      #1;
      n_vec++;
      if (bus.rf_we !== 1'b0 || bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1 || bus.rsp_data !== 32'd0) begin
         n_err++;
         $display("FAIL async_reset: we=%b valid=%b rdy=%b data=%h, required 0 0 1 0",
                  bus.rf_we, bus.rsp_valid, bus.cmd_ready, bus.rsp_data);
      end
      @(posedge clk);
      #1;
      n_vec++;
      if (mem[9] !== 32'h11) begin
         n_err++;
         $display("FAIL reset_no_write: r9=%h, required 00000011", mem[9]);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      n_vec++;
      if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_idle: rdy=%b valid=%b, required 1 0", bus.cmd_ready, bus.rsp_valid);
      end
   endtask

   task automatic test_directed_ops();
      logic [31:0] got;
      preload(5'd1, 32'h0000_0005);
      preload(5'd2, 32'hFFFF_FFFF);
      do_cmd(3'd0, 5'd3, 5'd1, 5'd2, got);
      n_vec++;
      if (got !== 32'h4) begin n_err++; $display("FAIL add_wrap: got %h, required 00000004", got); end
      do_cmd(3'd7, 5'd4, 5'd3, 5'd0, got);
      n_vec++;
      if (got !== 32'h4) begin n_err++; $display("FAIL mov: got %h, required 00000004", got); end
      preload(5'd1, 32'd0);
      preload(5'd2, 32'd1);
      do_cmd(3'd1, 5'd5, 5'd1, 5'd2, got);
      n_vec++;
      if (got !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL sub_borrow: got %h, required ffffffff", got); end
      preload(5'd1, 32'h1);
      preload(5'd2, 32'h25);
      do_cmd(3'd5, 5'd6, 5'd1, 5'd2, got);
      n_vec++;
      if (got !== 32'h20) begin n_err++; $display("FAIL sll: got %h, required 00000020", got); end
      preload(5'd1, 32'h8000_0000);
      preload(5'd2, 32'd31);
      do_cmd(3'd6, 5'd7, 5'd1, 5'd2, got);
      n_vec++;
      if (got !== 32'h1) begin n_err++; $display("FAIL srl: got %h, required 00000001", got); end
   endtask

   task automatic test_back_to_back();
      logic [31:0] got;
      preload(5'd1, 32'd3);
      do_cmd(3'd0, 5'd1, 5'd1, 5'd1, got);
      n_vec++;
      if (got !== 32'd6) begin n_err++; $display("FAIL hazard_1: got %h, required 00000006", got); end
      do_cmd(3'd0, 5'd1, 5'd1, 5'd1, got);
      n_vec++;
      if (got !== 32'd12) begin n_err++; $display("FAIL hazard_2: got %h, required 0000000c", got); end
   endtask

   task automatic test_handshake();
      int acc;
      logic [31:0] pend_exp;
      logic [4:0]  pend_rd;
      acc = 0; pend_exp = '0; pend_rd = '0;
      for (int i = 0; i < 9; i++) begin
         @(negedge clk);
         bus.cmd_valid = 1'b1;
         bus.cmd_op = 3'($urandom); bus.cmd_rd = 5'($urandom_range(1, 31));
         bus.cmd_rs1 = 5'($urandom); bus.cmd_rs2 = 5'($urandom);
         n_vec++;
         if (bus.cmd_ready !== (i % 3 == 0)) begin
            n_err++;
            $display("FAIL ready_pattern[%0d]: got %b, required %b", i, bus.cmd_ready, (i % 3 == 0));
         end
         if (i % 3 == 2) begin
            n_vec++;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_data !== pend_exp) begin
               n_err++;
               $display("FAIL stream_rsp[%0d]: valid=%b data=%h, required 1 %h", i, bus.rsp_valid, bus.rsp_data, pend_exp);
            end
            model[pend_rd] = pend_exp;
         end
         if (bus.cmd_ready === 1'b1) begin
            acc++;
            pend_exp = ref_op(int'(bus.cmd_op), operand(bus.cmd_rs1), operand(bus.cmd_rs2));
            pend_rd  = bus.cmd_rd;
         end
      end
      bus.cmd_valid = 1'b0;
      n_vec++;
      if (acc != 3) begin n_err++; $display("FAIL accept_count: got %0d, required 3", acc); end
   endtask

   task automatic test_random();
      logic [31:0] got;
      for (int i = 0; i < 32; i++) preload(5'(i), $urandom);
      for (int i = 0; i < 40; i++)
         do_cmd(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                5'($urandom_range(0, 31)), got);
   endtask

`ifdef ZERO_REG_EN
   task automatic test_zero_reg();
      logic [31:0] got;
      preload(5'd0, 32'h55);
      preload(5'd2, 32'd7);
      do_cmd(3'd0, 5'd0, 5'd0, 5'd2, got);
      n_vec++;
      if (got !== 32'd7) begin n_err++; $display("FAIL zero_operand: got %h, required 00000007", got); end
      @(posedge clk);
      #1;
      n_vec++;
      if (mem[0] !== 32'h55) begin n_err++; $display("FAIL zero_no_write: r0=%h, required 00000055", mem[0]); end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

   initial begin
      bus.cmd_valid = 1'b0; bus.cmd_op = '0; bus.cmd_rd = '0; bus.cmd_rs1 = '0; bus.cmd_rs2 = '0;
      for (int i = 0; i < 32; i++) begin
         mem[i] = '0;
         model[i] = '0;
      end
      test_reset();
      test_reset_mid_wb();
      test_directed_ops();
      test_back_to_back();
      test_handshake();
      test_random();
`ifdef ZERO_REG_EN
      test_zero_reg();
`endif
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
